// File: rtl/alu_rs_if.sv
// Dispatch, result-broadcast and issue bus of the ALU reservation station.
// The station uses the slave view; the dispatch/ALU side uses the master view.
interface alu_rs_if #(
  parameter int OP_W  = 6,
  parameter int ROB_W = 4
);
  logic             disp_valid;
  logic [OP_W-1:0]  disp_op;
  logic [ROB_W-1:0] disp_rob;
  logic [31:0]      disp_vj;
  logic [31:0]      disp_vk;
  logic             disp_qj_busy;
  logic             disp_qk_busy;
  logic [ROB_W-1:0] disp_qj;
  logic [ROB_W-1:0] disp_qk;
  logic             cdb_alu_valid;
  logic [ROB_W-1:0] cdb_alu_rob;
  logic [31:0]      cdb_alu_val;
  logic             cdb_lsb_valid;
  logic [ROB_W-1:0] cdb_lsb_rob;
  logic [31:0]      cdb_lsb_val;
  logic             rs_full;
  logic             issue_status;
  logic [OP_W-1:0]  issue_op;
  logic [31:0]      issue_rs1;
  logic [31:0]      issue_rs2;
  logic [ROB_W-1:0] issue_rob;

  modport slave (
    input  disp_valid, disp_op, disp_rob, disp_vj, disp_vk,
           disp_qj_busy, disp_qk_busy, disp_qj, disp_qk,
           cdb_alu_valid, cdb_alu_rob, cdb_alu_val,
           cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_val,
    output rs_full, issue_status, issue_op, issue_rs1, issue_rs2, issue_rob
  );

  modport master (
    output disp_valid, disp_op, disp_rob, disp_vj, disp_vk,
           disp_qj_busy, disp_qk_busy, disp_qj, disp_qk,
           cdb_alu_valid, cdb_alu_rob, cdb_alu_val,
           cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_val,
    input  rs_full, issue_status, issue_op, issue_rs1, issue_rs2, issue_rob
  );
endinterface

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers dispatched ops, snoops the
// ALU/LSB result buses for pending operands and issues one ready op per cycle.
module alu_rs #(
  parameter int ENTRIES = 8,
  parameter int OP_W    = 6,
  parameter int ROB_W   = 4
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     clear,
  alu_rs_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic        busy;
    logic [31:0] val;
  } opnd_t;

  logic [ENTRIES-1:0] r_busy;
  logic [OP_W-1:0]    r_op    [ENTRIES];
  logic [ROB_W-1:0]   r_rob   [ENTRIES];
  logic [31:0]        r_vj    [ENTRIES];
  logic [31:0]        r_vk    [ENTRIES];
  logic               r_qj_busy [ENTRIES];
  logic               r_qk_busy [ENTRIES];
  logic [ROB_W-1:0]   r_qj    [ENTRIES];
  logic [ROB_W-1:0]   r_qk    [ENTRIES];

  logic               r_iss_status;
  logic [OP_W-1:0]    r_iss_op;
  logic [31:0]        r_iss_rs1;
  logic [31:0]        r_iss_rs2;
  logic [ROB_W-1:0]   r_iss_rob;

  logic [ENTRIES-1:0] w_ready;
  logic               w_iss_vld;
  logic [IDX_W-1:0]   w_iss_idx;
  logic               w_free_vld;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_disp_take;
  opnd_t              w_j [ENTRIES];
  opnd_t              w_k [ENTRIES];
  opnd_t              w_dj;
  opnd_t              w_dk;

  // A pending operand grabs a matching broadcast; the ALU bus wins a tag tie.
  function automatic opnd_t resolve(
    input logic             qb,
    input logic [ROB_W-1:0] q,
    input logic [31:0]      v,
    input logic             av,
    input logic [ROB_W-1:0] at,
    input logic [31:0]      aval,
    input logic             lv,
    input logic [ROB_W-1:0] lt,
    input logic [31:0]      lval
  );
    opnd_t o;
    o.busy = qb;
    o.val  = v;
    if (qb && av && (at == q)) begin
      o.busy = 1'b0;
      o.val  = aval;
    end else if (qb && lv && (lt == q)) begin
      o.busy = 1'b0;
      o.val  = lval;
    end
    return o;
  endfunction

  always_comb begin
    w_iss_vld  = 1'b0;
    w_iss_idx  = '0;
    w_free_vld = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      w_ready[i] = r_busy[i] && !r_qj_busy[i] && !r_qk_busy[i];
      if (w_ready[i]) begin
        w_iss_vld = 1'b1;
        w_iss_idx = IDX_W'(i);
      end
      if (!r_busy[i]) begin
        w_free_vld = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      w_j[i] = resolve(r_qj_busy[i], r_qj[i], r_vj[i],
                       bus.cdb_alu_valid, bus.cdb_alu_rob, bus.cdb_alu_val,
                       bus.cdb_lsb_valid, bus.cdb_lsb_rob, bus.cdb_lsb_val);
      w_k[i] = resolve(r_qk_busy[i], r_qk[i], r_vk[i],
                       bus.cdb_alu_valid, bus.cdb_alu_rob, bus.cdb_alu_val,
                       bus.cdb_lsb_valid, bus.cdb_lsb_rob, bus.cdb_lsb_val);
    end
    w_dj = resolve(bus.disp_qj_busy, bus.disp_qj, bus.disp_vj,
                   bus.cdb_alu_valid, bus.cdb_alu_rob, bus.cdb_alu_val,
                   bus.cdb_lsb_valid, bus.cdb_lsb_rob, bus.cdb_lsb_val);
    w_dk = resolve(bus.disp_qk_busy, bus.disp_qk, bus.disp_vk,
                   bus.cdb_alu_valid, bus.cdb_alu_rob, bus.cdb_alu_val,
                   bus.cdb_lsb_valid, bus.cdb_lsb_rob, bus.cdb_lsb_val);
    w_disp_take = bus.disp_valid && w_free_vld;
  end

  // Selection and free-slot search both use registered state, so a slot
  // freed by issue only becomes visible to dispatch on the following cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_in || clear) begin
      r_busy       <= '0;
      r_iss_status <= 1'b0;
      r_iss_op     <= '0;
      r_iss_rs1    <= '0;
      r_iss_rs2    <= '0;
      r_iss_rob    <= '0;
    end else if (!rdy_in) begin
      r_iss_status <= 1'b0;
    end else begin
      r_iss_status <= w_iss_vld;
      if (w_iss_vld) begin
        r_iss_op  <= r_op[w_iss_idx];
        r_iss_rs1 <= r_vj[w_iss_idx];
        r_iss_rs2 <= r_vk[w_iss_idx];
        r_iss_rob <= r_rob[w_iss_idx];
        r_busy[w_iss_idx] <= 1'b0;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (r_busy[i]) begin
          r_qj_busy[i] <= w_j[i].busy;
          r_vj[i]      <= w_j[i].val;
          r_qk_busy[i] <= w_k[i].busy;
          r_vk[i]      <= w_k[i].val;
        end
      end
      if (w_disp_take) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_op[w_free_idx]      <= bus.disp_op;
        r_rob[w_free_idx]     <= bus.disp_rob;
        r_qj[w_free_idx]      <= bus.disp_qj;
        r_qk[w_free_idx]      <= bus.disp_qk;
        r_qj_busy[w_free_idx] <= w_dj.busy;
        r_vj[w_free_idx]      <= w_dj.val;
        r_qk_busy[w_free_idx] <= w_dk.busy;
        r_vk[w_free_idx]      <= w_dk.val;
      end
    end
  end

  assign bus.rs_full      = &r_busy;
  assign bus.issue_status = r_iss_status;
  assign bus.issue_op     = r_iss_op;
  assign bus.issue_rs1    = r_iss_rs1;
  assign bus.issue_rs2    = r_iss_rs2;
  assign bus.issue_rob    = r_iss_rob;
endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: table of single-op transactions plus directed sequences
// for full, stall and flush behaviour.
module tb_alu_rs;
  logic clk_in;
  logic rst_in;
  logic rdy_in;
  logic clear;
  int   checks;
  int   failures;

  alu_rs_if #(.OP_W(6), .ROB_W(4)) bus ();

  alu_rs #(.ENTRIES(8), .OP_W(6), .ROB_W(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  rob;
    logic [31:0] vj, vk;
    logic        qjb, qkb;
    logic [3:0]  qj, qk;
    logic        dav, dlv;       // broadcasts in the dispatch cycle
    logic [3:0]  dat, dlt;
    logic [31:0] daval, dlval;
    logic        wav, wlv;       // broadcasts in the following cycle
    logic [3:0]  wat, wlt;
    logic [31:0] waval, wlval;
    int          lat;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(
    input logic [5:0] op, input logic [3:0] rob, input logic [31:0] vj, input logic [31:0] vk,
    input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk,
    input logic dav, input logic [3:0] dat, input logic [31:0] daval,
    input logic dlv, input logic [3:0] dlt, input logic [31:0] dlval,
    input logic wav, input logic [3:0] wat, input logic [31:0] waval,
    input logic wlv, input logic [3:0] wlt, input logic [31:0] wlval,
    input int lat, input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.op = op; v.rob = rob; v.vj = vj; v.vk = vk;
    v.qjb = qjb; v.qj = qj; v.qkb = qkb; v.qk = qk;
    v.dav = dav; v.dat = dat; v.daval = daval;
    v.dlv = dlv; v.dlt = dlt; v.dlval = dlval;
    v.wav = wav; v.wat = wat; v.waval = waval;
    v.wlv = wlv; v.wlt = wlt; v.wlval = wlval;
    v.lat = lat; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid    = 1'b0;
    bus.disp_op       = '0;
    bus.disp_rob      = '0;
    bus.disp_vj       = '0;
    bus.disp_vk       = '0;
    bus.disp_qj_busy  = 1'b0;
    bus.disp_qk_busy  = 1'b0;
    bus.disp_qj       = '0;
    bus.disp_qk       = '0;
    bus.cdb_alu_valid = 1'b0;
    bus.cdb_alu_rob   = '0;
    bus.cdb_alu_val   = '0;
    bus.cdb_lsb_valid = 1'b0;
    bus.cdb_lsb_rob   = '0;
    bus.cdb_lsb_val   = '0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [3:0] rob, input logic [31:0] vj,
                      input logic [31:0] vk, input logic qjb, input logic [3:0] qj);
    bus.disp_valid   = 1'b1;
    bus.disp_op      = op;
    bus.disp_rob     = rob;
    bus.disp_vj      = vj;
    bus.disp_vk      = vk;
    bus.disp_qj_busy = qjb;
    bus.disp_qj      = qj;
    bus.disp_qk_busy = 1'b0;
    bus.disp_qk      = '0;
  endtask

  initial begin
    int  lat;
    bit  seen;
    checks   = 0;
    failures = 0;

    vecs[0] = mk(6'd3, 4'd2, 32'd5, 32'd7, 0, 4'd0, 0, 4'd0,
                 0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 2, 32'd5, 32'd7);
    vecs[1] = mk(6'd1, 4'd1, 32'hDEAD, 32'd1, 1, 4'd6, 0, 4'd0,
                 0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 4'd6, 32'h10, 3, 32'h10, 32'd1);
    vecs[2] = mk(6'd4, 4'd3, 32'd2, 32'hBEEF, 0, 4'd0, 1, 4'd4,
                 1, 4'd4, 32'd9, 0, 4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 2, 32'd2, 32'd9);
    vecs[3] = mk(6'd5, 4'd8, 32'd0, 32'd0, 1, 4'd3, 1, 4'd5,
                 0, 4'd0, 0, 0, 4'd0, 0, 1, 4'd3, 32'h111, 1, 4'd5, 32'h222, 3, 32'h111, 32'h222);
    vecs[4] = mk(6'h3F, 4'd15, 32'd0, 32'h42, 1, 4'd7, 0, 4'd0,
                 0, 4'd0, 0, 0, 4'd0, 0, 1, 4'd7, 32'hAAAA, 1, 4'd7, 32'hBBBB, 3, 32'hAAAA, 32'h42);
    vecs[5] = mk(6'd9, 4'd0, 32'd0, 32'h77, 1, 4'd9, 0, 4'd9,
                 0, 4'd0, 0, 1, 4'd9, 32'h55, 0, 4'd0, 0, 0, 4'd0, 0, 2, 32'h55, 32'h77);

    rst_in = 1'b0;
    rdy_in = 1'b1;
    clear  = 1'b0;
    idle();
    disp(6'd1, 4'd1, 32'd1, 32'd1, 0, 4'd0);
    tick();
    tick();
    chk("rst_status", 32'(bus.issue_status), 32'd0);
    chk("rst_full",   32'(bus.rs_full), 32'd0);
    chk("rst_op",     32'(bus.issue_op), 32'd0);
    chk("rst_rs1",    bus.issue_rs1, 32'd0);
    chk("rst_rs2",    bus.issue_rs2, 32'd0);
    chk("rst_rob",    32'(bus.issue_rob), 32'd0);
    idle();
    rst_in = 1'b1;
    tick();
    chk("rst_no_issue", 32'(bus.issue_status), 32'd0);

    for (int v = 0; v < 6; v++) begin
      idle();
      bus.disp_valid    = 1'b1;
      bus.disp_op       = vecs[v].op;
      bus.disp_rob      = vecs[v].rob;
      bus.disp_vj       = vecs[v].vj;
      bus.disp_vk       = vecs[v].vk;
      bus.disp_qj_busy  = vecs[v].qjb;
      bus.disp_qj       = vecs[v].qj;
      bus.disp_qk_busy  = vecs[v].qkb;
      bus.disp_qk       = vecs[v].qk;
      bus.cdb_alu_valid = vecs[v].dav;
      bus.cdb_alu_rob   = vecs[v].dat;
      bus.cdb_alu_val   = vecs[v].daval;
      bus.cdb_lsb_valid = vecs[v].dlv;
      bus.cdb_lsb_rob   = vecs[v].dlt;
      bus.cdb_lsb_val   = vecs[v].dlval;
      tick();
      idle();
      bus.cdb_alu_valid = vecs[v].wav;
      bus.cdb_alu_rob   = vecs[v].wat;
      bus.cdb_alu_val   = vecs[v].waval;
      bus.cdb_lsb_valid = vecs[v].wlv;
      bus.cdb_lsb_rob   = vecs[v].wlt;
      bus.cdb_lsb_val   = vecs[v].wlval;
      tick();
      idle();
      lat  = 2;
      seen = 0;
      for (int n = 0; n < 6 && !seen; n++) begin
        if (bus.issue_status) seen = 1;
        else begin
          tick();
          lat++;
        end
      end
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      if (seen) begin
        chk($sformatf("v%0d_op", v),  32'(bus.issue_op),  32'(vecs[v].op));
        chk($sformatf("v%0d_rob", v), 32'(bus.issue_rob), 32'(vecs[v].rob));
        chk($sformatf("v%0d_rs1", v), bus.issue_rs1, vecs[v].e1);
        chk($sformatf("v%0d_rs2", v), bus.issue_rs2, vecs[v].e2);
        tick();
        chk($sformatf("v%0d_pulse_end", v), 32'(bus.issue_status), 32'd0);
      end
    end

    // Full: eight ops waiting on tag 15, ninth dropped, then drain in order.
    for (int i = 0; i < 8; i++) begin
      idle();
      disp(6'(i + 1), 4'(i), 32'd0, 32'(i), 1, 4'd15);
      tick();
    end
    idle();
    chk("full_set", 32'(bus.rs_full), 32'd1);
    disp(6'd2, 4'd8, 32'h99, 32'h99, 0, 4'd0);
    tick();
    idle();
    chk("full_hold", 32'(bus.rs_full), 32'd1);
    chk("full_no_issue", 32'(bus.issue_status), 32'd0);
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_rob   = 4'd15;
    bus.cdb_alu_val   = 32'h1234;
    tick();
    idle();
    chk("full_wake_edge", 32'(bus.issue_status), 32'd0);
    tick();
    chk("full_clear_after_first", 32'(bus.rs_full), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_status", i), 32'(bus.issue_status), 32'd1);
      chk($sformatf("drain%0d_rob", i), 32'(bus.issue_rob), 32'(i));
      chk($sformatf("drain%0d_rs1", i), bus.issue_rs1, 32'h1234);
      chk($sformatf("drain%0d_rs2", i), bus.issue_rs2, 32'(i));
      tick();
    end
    chk("drain_done", 32'(bus.issue_status), 32'd0);
    tick();
    chk("drain_ninth_dropped", 32'(bus.issue_status), 32'd0);

    // Stall: a ready slot must wait out three stalled edges, then issue once.
    disp(6'd7, 4'd5, 32'hA, 32'hB, 0, 4'd0);
    tick();
    idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.cdb_alu_valid = 1'b1;
      tick();
      chk($sformatf("stall%0d_status", i), 32'(bus.issue_status), 32'd0);
    end
    idle();
    rdy_in = 1'b1;
    tick();
    chk("stall_release_status", 32'(bus.issue_status), 32'd1);
    chk("stall_release_rob", 32'(bus.issue_rob), 32'd5);
    chk("stall_release_rs1", bus.issue_rs1, 32'hA);
    tick();
    chk("stall_once_a", 32'(bus.issue_status), 32'd0);
    tick();
    chk("stall_once_b", 32'(bus.issue_status), 32'd0);

    // Flush: four pending slots plus one issuable slot, cleared together.
    for (int i = 0; i < 4; i++) begin
      idle();
      disp(6'd1, 4'(i + 10), 32'd0, 32'd0, 1, 4'd14);
      tick();
    end
    idle();
    disp(6'd2, 4'd7, 32'h44, 32'h45, 0, 4'd0);
    tick();
    idle();
    clear = 1'b1;
    disp(6'd3, 4'd9, 32'h66, 32'h67, 0, 4'd0);
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_rob   = 4'd14;
    bus.cdb_alu_val   = 32'h5A;
    tick();
    clear = 1'b0;
    idle();
    chk("flush_status", 32'(bus.issue_status), 32'd0);
    chk("flush_full",   32'(bus.rs_full), 32'd0);
    chk("flush_rs1",    bus.issue_rs1, 32'd0);
    chk("flush_rob",    32'(bus.issue_rob), 32'd0);
    bus.cdb_alu_valid = 1'b1;
    bus.cdb_alu_rob   = 4'd14;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("flush_quiet%0d", i), 32'(bus.issue_status), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station that feeds the integer ALU. It buffers dispatched instructions, waits for their operands by snooping the ALU and load-store result broadcasts, and issues one ready instruction per cycle. Each issue drives the ALU's `status`/`OpCode`/`rs1`/`rs2`/`ROB_Number` inputs. It sits between the dispatch stage and the ALU, and is flushed together with the ROB on `clear`.

## Interface
- `ENTRIES`, 8: number of station slots (power of two, ≥2).
- `OP_W`, 6: opcode width, matching the ALU opcode bus.
- `ROB_W`, 4: ROB tag width.
- `clk_in` in 1: the single clock; all state updates on the rising edge.
- `rst_in` in 1: synchronous, active-low reset.
- `rdy_in` in 1: global ready; low means stall.
- `clear` in 1: synchronous flush on mispredict.
- `disp_valid` in 1: dispatch request.
- `disp_op` in OP_W: opcode.
- `disp_rob` in ROB_W: destination ROB tag.
- `disp_vj`, `disp_vk` in 32: operand values. Immediate or PC values are pre-placed in these by the decoder.
- `disp_qj_busy`, `disp_qk_busy` in 1: operand still pending.
- `disp_qj`, `disp_qk` in ROB_W: producer tags of pending operands.
- `cdb_alu_valid` in 1, `cdb_alu_rob` in ROB_W, `cdb_alu_val` in 32: ALU result broadcast.
- `cdb_lsb_valid` in 1, `cdb_lsb_rob` in ROB_W, `cdb_lsb_val` in 32: load result broadcast.
- `rs_full` out 1: no free slot.
- `issue_status` out 1: issue pulse to the ALU `status` input.
- `issue_op` out OP_W, `issue_rs1` out 32, `issue_rs2` out 32, `issue_rob` out ROB_W: registered issue payload.

## Operation
- Each slot holds `busy`, `op`, `rob`, `vj`, `qj_busy`, `qj`, `vk`, `qk_busy`, `qk`.
- An operand is ready when its `q*_busy` bit is 0. A slot is issuable when it is busy and both operands are ready.
- Priority order: reset, then `clear`, then `!rdy_in`, then normal operation.
- Reset (`rst_in`=0):
  - All slot `busy` bits are 0.
  - `issue_status`=0; `issue_op`, `issue_rs1`, `issue_rs2`, `issue_rob` = 0.
  - `rs_full`=0.
- `clear`=1 (independent of `rdy_in`): same effect as reset. Any dispatch or broadcast in that cycle is ignored.
- `rdy_in`=0:
  - All slots hold their contents.
  - `issue_status` is registered to 0; the payload registers hold.
  - Dispatch and broadcasts are ignored. Producers must re-present them.
- Normal cycle (`rdy_in`=1). All of the following happen in one cycle:
  - **Dispatch.** Taken if `disp_valid` and `!rs_full`. The request is written into the lowest-index free slot. Dispatch while `rs_full`=1 is dropped silently.
  - **Dispatch bypass.** If a dispatched operand is busy and its tag equals a valid broadcast tag in the same cycle, store the broadcast value and mark the operand ready.
  - **Wakeup.** For every busy slot and each operand, a valid broadcast whose tag matches a pending `q` captures `val` and clears the busy bit. Both buses may wake different operands of the same slot in the same cycle. If both buses carry the same tag, the ALU bus wins.
  - **Issue.** Select the lowest-index slot that is issuable in the registered state at the start of the cycle. Drive the issue registers from it: `issue_rs1`=`vj`, `issue_rs2`=`vk`, `issue_status`=1. Free that slot. If no slot is issuable, `issue_status`=0.
- A freed slot may be reused by a dispatch in the next cycle, not the same cycle.
- `rs_full` = (all `ENTRIES` slots busy), decoded from registered state. A slot issuing in the same cycle does not clear `rs_full` until the next cycle.

## Timing
- **Dispatch with both operands ready at edge E0.** Slot written at E0, selected at E1. `issue_status`=1 for the cycle after E1. Minimum latency: 2 edges.
- **Wakeup at edge E0.** The woken slot is issuable at E1 at the earliest, never at E0.
- **Issue pulse.** `issue_status` lasts exactly one cycle per issue. At most one issue per cycle, so back-to-back ready slots produce consecutive pulses.
- **Stall release.** After `rdy_in` rises, issue resumes at the first rising edge with `rdy_in`=1. No slot is lost or duplicated across a stall.
- **Reset or clear mid-operation.** Takes effect at the next edge. No issue pulse follows that edge.

## Test plan
- **Basic issue.** Reset, then dispatch op=3, rob=2, vj=5, vk=7, both ready. Required: `issue_status`=1 two edges later with rs1=5, rs2=7, rob=2, op=3, then 0 the following cycle.
- **Wakeup.** Dispatch rob=1 with qj_busy tag=6, vk=1. Then `cdb_lsb_valid`, rob=6, val=0x10. Required: issue one edge after the broadcast edge with rs1=0x10.
- **Dispatch bypass.** Dispatch with qk tag=4 in the same cycle as `cdb_alu_valid` rob=4, val=9. Required: issue at dispatch+2 with rs2=9.
- **Full.** Fill all 8 slots with operands waiting on tag 15. Required: `rs_full`=1, and a ninth dispatch is dropped. Broadcast tag 15: required 8 consecutive issue pulses in slot order 0–7, and `rs_full`=0 after the first issue.
- **Stall.** Hold `rdy_in`=0 for 3 cycles while a ready slot exists. Required: `issue_status` stays 0, then the slot issues exactly once after `rdy_in` returns to 1.
- **Flush.** Assert `clear` with 5 busy slots and a dispatch in the same cycle. Required: `issue_status`=0 and `rs_full`=0 next cycle, and no further issues without new dispatches.
